// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_copy word-copy engine.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr
    } state_t;

    // Register select, taken from address bits [3:2].
    localparam logic [1:0] RegSrc   = 2'd0;
    localparam logic [1:0] RegDst   = 2'd1;
    localparam logic [1:0] RegCount = 2'd2;
    localparam logic [1:0] RegCtrl  = 2'd3;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlBusy  = 1;
    localparam int unsigned CtrlDone  = 2;
    localparam int unsigned CtrlError = 3;
    localparam int unsigned CtrlAbort = 4;

    localparam logic [31:0] DmaBaseAddr = 32'h0004_0000;

endpackage

// File: rtl/dma_copy.sv
// Memory-to-memory word-copy engine: four-register slave front end plus a
// read-then-write bus master sequencer.
module dma_copy
    import dma_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] m_address_out,
    output logic        m_read_out,
    output logic        m_write_out,
    input  logic [31:0] m_read_value_in,
    output logic [3:0]  m_write_mask_out,
    output logic [31:0] m_write_value_out,
    input  logic        m_ready_in,
    input  logic        m_fault_in,
    output logic        irq_out
);

    state_t                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]            buf_q, buf_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   abort_q, abort_d;

    logic        busy;
    logic        wr_en;
    logic        ctrl_wr;
    logic        start;
    logic        abort_wr;
    logic [1:0]  reg_sel;
    logic [31:0] reg_rdata;
    logic        unused_bits;

    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1]};

    assign busy     = (state_q != StIdle);
    assign reg_sel  = address_in[3:2];
    assign wr_en    = sel_in & write_mask_in[0];
    assign ctrl_wr  = wr_en && (reg_sel == RegCtrl);
    assign start    = ctrl_wr & write_value_in[CtrlStart] & ~busy;
    assign abort_wr = ctrl_wr & write_value_in[CtrlAbort] & busy;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        buf_d   = buf_q;
        done_d  = done_q;
        error_d = error_q;
        abort_d = abort_q;

        if (wr_en && !busy) begin
            case (reg_sel)
                RegSrc:   src_d   = {write_value_in[31:2], 2'b00};
                RegDst:   dst_d   = {write_value_in[31:2], 2'b00};
                RegCount: count_d = write_value_in[COUNT_WIDTH-1:0];
                default:  ;
            endcase
        end

        if (ctrl_wr) begin
            if (write_value_in[CtrlDone])  done_d  = 1'b0;
            if (write_value_in[CtrlError]) error_d = 1'b0;
        end
        if (abort_wr) abort_d = 1'b1;

        if (start) begin
            if (count_q != '0) begin
                state_d = StRd;
                done_d  = 1'b0;
                error_d = 1'b0;
                abort_d = 1'b0;
            end else begin
                done_d = 1'b1;
            end
        end

        // Completion events come after the W1C handling so a same-edge set wins.
        case (state_q)
            StRd: begin
                if (m_ready_in) begin
                    if (m_fault_in) begin
                        state_d = StIdle;
                        error_d = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        buf_d   = m_read_value_in;
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (m_ready_in) begin
                    if (m_fault_in) begin
                        state_d = StIdle;
                        error_d = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        src_d   = src_q + 32'd4;
                        dst_d   = dst_q + 32'd4;
                        count_d = count_q - COUNT_WIDTH'(1);
                        if (count_q == COUNT_WIDTH'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            abort_d = 1'b0;
                        end else if (abort_q || abort_wr) begin
                            state_d = StIdle;
                            abort_d = 1'b0;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            error_q <= error_d;
            abort_q <= abort_d;
        end
    end

    // Master requests are gated by reset so an in-flight beat is dropped at once.
    always_comb begin
        m_address_out     = '0;
        m_read_out        = 1'b0;
        m_write_out       = 1'b0;
        m_write_mask_out  = 4'b0000;
        m_write_value_out = '0;
        if (!reset) begin
            case (state_q)
                StRd: begin
                    m_address_out = src_q;
                    m_read_out    = 1'b1;
                end
                StWr: begin
                    m_address_out     = dst_q;
                    m_write_out       = 1'b1;
                    m_write_mask_out  = 4'b1111;
                    m_write_value_out = buf_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            RegSrc:   reg_rdata = src_q;
            RegDst:   reg_rdata = dst_q;
            RegCount: reg_rdata = 32'(count_q);
            default:  reg_rdata = {27'd0, error_q, done_q, busy, 1'b0};
        endcase
    end

    assign read_value_out = (sel_in && read_in) ? reg_rdata : 32'd0;
    assign ready_out      = sel_in;
    assign irq_out        = done_q | error_q;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: RAM model with programmable wait states and
// read-fault injection, checked against hand-computed register and memory values.
module tb_dma_copy;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;
    logic [31:0] m_address_out;
    logic        m_read_out;
    logic        m_write_out;
    logic [31:0] m_read_value_in;
    logic [3:0]  m_write_mask_out;
    logic [31:0] m_write_value_out;
    logic        m_ready_in;
    logic        m_fault_in;
    logic        irq_out;

    always #5 clk = ~clk;

    dma_copy #(.COUNT_WIDTH(16)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .address_in        (address_in),
        .sel_in            (sel_in),
        .read_in           (read_in),
        .read_value_out    (read_value_out),
        .write_mask_in     (write_mask_in),
        .write_value_in    (write_value_in),
        .ready_out         (ready_out),
        .m_address_out     (m_address_out),
        .m_read_out        (m_read_out),
        .m_write_out       (m_write_out),
        .m_read_value_in   (m_read_value_in),
        .m_write_mask_out  (m_write_mask_out),
        .m_write_value_out (m_write_value_out),
        .m_ready_in        (m_ready_in),
        .m_fault_in        (m_fault_in),
        .irq_out           (irq_out)
    );

    // Bus slave model: reads from src_mem, writes land in dst_mem.
    logic [31:0] src_mem [0:255];
    logic [31:0] dst_mem [0:255];
    int          wait_n = 0;
    int          wait_cnt = 0;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h0;

    int          req_cycles = 0;
    int          rd_beats = 0;
    int          wr_beats = 0;
    int          both_err = 0;
    int          stab_err = 0;
    logic        pend_q = 1'b0;
    logic [69:0] pend_snap = '0;
    logic [69:0] cur_snap;

    assign m_ready_in      = (m_read_out || m_write_out) && (wait_cnt == wait_n);
    assign m_read_value_in = src_mem[m_address_out[9:2]];
    assign m_fault_in      = fault_en && m_read_out && m_ready_in && (m_address_out == fault_addr);
    assign cur_snap = {m_address_out, m_read_out, m_write_out, m_write_value_out, m_write_mask_out};

    always @(posedge clk) begin
        if (m_read_out || m_write_out) req_cycles <= req_cycles + 1;
        if (m_read_out && m_ready_in) rd_beats <= rd_beats + 1;
        if (m_write_out && m_ready_in) begin
            wr_beats <= wr_beats + 1;
            dst_mem[m_address_out[9:2]] <= m_write_value_out;
        end
        if (m_read_out && m_write_out) both_err <= both_err + 1;
        if (pend_q && !reset && (cur_snap != pend_snap)) stab_err <= stab_err + 1;
        pend_q    <= (m_read_out || m_write_out) && !m_ready_in && !reset;
        pend_snap <= cur_snap;
        if (reset || m_ready_in) wait_cnt <= 0;
        else if (m_read_out || m_write_out) wait_cnt <= wait_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] r);
        return {DmaBaseAddr[31:4], r, 2'b00};
    endfunction

    // Both bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        address_in     = reg_addr(r);
        sel_in         = 1'b1;
        write_mask_in  = 4'b1111;
        write_value_in = d;
        @(negedge clk);
        sel_in        = 1'b0;
        write_mask_in = 4'b0000;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        address_in = reg_addr(r);
        sel_in     = 1'b1;
        read_in    = 1'b1;
        #1;
        d = read_value_out;
        @(negedge clk);
        sel_in  = 1'b0;
        read_in = 1'b0;
    endtask

    task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        bus_write(RegSrc, s);
        bus_write(RegDst, d);
        bus_write(RegCount, n);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        v = 32'h2;
        for (int i = 0; i < 2000 && v[CtrlBusy]; i++) bus_read(RegCtrl, v);
        check("idle_timeout", {31'd0, v[CtrlBusy]}, 32'd0);
    endtask

    logic [31:0] v;
    int          r0;
    int          w0;
    int          hunt;

    initial begin
        reset          = 1'b1;
        address_in     = '0;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        write_mask_in  = '0;
        write_value_in = '0;
        for (int i = 0; i < 10; i++) src_mem[8'h40 + i] = 32'h1111_1111 * (i + 1);
        src_mem[255] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_mrd", {31'd0, m_read_out}, 32'd0);
        check("rst_mwr", {31'd0, m_write_out}, 32'd0);
        check("rst_maddr", m_address_out, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        check("rst_rdata_nosel", read_value_out, 32'd0);
        bus_read(RegSrc, v);   check("rst_src", v, 32'd0);
        bus_read(RegDst, v);   check("rst_dst", v, 32'd0);
        bus_read(RegCount, v); check("rst_count", v, 32'd0);
        bus_read(RegCtrl, v);  check("rst_ctrl", v, 32'd0);

        // Field masking while idle
        bus_write(RegSrc, 32'h0000_0103);
        bus_read(RegSrc, v);   check("src_lowbits", v, 32'h0000_0100);
        bus_write(RegCount, 32'hABCD_1234);
        bus_read(RegCount, v); check("count_width", v, 32'h0000_1234);
        bus_write(RegCtrl, 32'h10);
        bus_read(RegCtrl, v);  check("abort_idle", v, 32'd0);

        // 4-word zero-wait copy
        setup(32'h100, 32'h200, 4);
        r0 = req_cycles;
        bus_write(RegCtrl, 32'h1);
        wait_idle();
        check("t1_busy_cycles", 32'(req_cycles - r0), 32'd8);
        for (int i = 0; i < 4; i++) check("t1_data", dst_mem[8'h80 + i], 32'h1111_1111 * (i + 1));
        bus_read(RegCtrl, v);  check("t1_ctrl", v, 32'h4);
        check("t1_irq", {31'd0, irq_out}, 32'd1);
        bus_read(RegCount, v); check("t1_count", v, 32'd0);
        bus_read(RegSrc, v);   check("t1_src", v, 32'h110);
        bus_read(RegDst, v);   check("t1_dst", v, 32'h210);

        // Same copy with 3 wait states per beat
        wait_n = 3;
        setup(32'h100, 32'h280, 4);
        r0 = req_cycles;
        bus_write(RegCtrl, 32'h1);
        wait_idle();
        wait_n = 0;
        check("t2_busy_cycles", 32'(req_cycles - r0), 32'd32);
        check("t2_stable", 32'(stab_err), 32'd0);
        for (int i = 0; i < 4; i++) check("t2_data", dst_mem[8'hA0 + i], 32'h1111_1111 * (i + 1));

        // W1C of DONE, then START with COUNT=0
        bus_write(RegCtrl, 32'h0C);
        bus_read(RegCtrl, v);  check("w1c_ctrl", v, 32'd0);
        check("w1c_irq", {31'd0, irq_out}, 32'd0);
        bus_write(RegCount, 32'd0);
        r0 = req_cycles;
        bus_write(RegCtrl, 32'h1);
        bus_read(RegCtrl, v);  check("t3_ctrl", v, 32'h4);
        repeat (3) @(negedge clk);
        check("t3_no_beats", 32'(req_cycles - r0), 32'd0);

        // Read fault on the third word
        fault_addr = 32'h108;
        fault_en   = 1'b1;
        setup(32'h100, 32'h200, 4);
        w0 = wr_beats;
        bus_write(RegCtrl, 32'h1);
        wait_idle();
        fault_en = 1'b0;
        bus_read(RegCtrl, v);  check("t4_ctrl", v, 32'h8);
        check("t4_irq", {31'd0, irq_out}, 32'd1);
        bus_read(RegSrc, v);   check("t4_src", v, 32'h108);
        bus_read(RegDst, v);   check("t4_dst", v, 32'h208);
        bus_read(RegCount, v); check("t4_count", v, 32'd2);
        check("t4_writes", 32'(wr_beats - w0), 32'd2);

        // ABORT during word 2's read of a 10-word copy
        setup(32'h100, 32'h380, 10);
        w0 = wr_beats;
        bus_write(RegCtrl, 32'h1);
        hunt = 0;
        while (hunt < 50 && !(m_read_out && m_address_out == 32'h104)) begin
            @(negedge clk);
            hunt++;
        end
        check("t5_found_rd2", {31'd0, hunt < 50}, 32'd1);
        bus_write(RegCtrl, 32'h10);
        wait_idle();
        bus_read(RegCount, v); check("t5_count", v, 32'd8);
        bus_read(RegCtrl, v);  check("t5_ctrl", v, 32'd0);
        bus_read(RegSrc, v);   check("t5_src", v, 32'h108);
        check("t5_word2", dst_mem[8'hE1], 32'h2222_2222);
        check("t5_writes", 32'(wr_beats - w0), 32'd2);

        // Source address wraps past 2^32
        setup(32'hFFFF_FFFC, 32'h300, 1);
        bus_write(RegCtrl, 32'h1);
        wait_idle();
        bus_read(RegSrc, v);   check("t6_src_wrap", v, 32'd0);
        bus_read(RegDst, v);   check("t6_dst", v, 32'h304);
        bus_read(RegCtrl, v);  check("t6_ctrl", v, 32'h4);
        check("t6_data", dst_mem[8'hC0], 32'hCAFE_F00D);

        // DST write ignored while busy, then reset mid-WR
        wait_n = 3;
        setup(32'h100, 32'h3C0, 4);
        w0 = wr_beats;
        bus_write(RegCtrl, 32'h1);
        bus_write(RegDst, 32'hDEAD_0000);
        bus_read(RegDst, v);   check("t7_dst_locked", v, 32'h3C0);
        hunt = 0;
        while (hunt < 50 && !m_write_out) begin
            @(negedge clk);
            hunt++;
        end
        check("t7_found_wr", {31'd0, hunt < 50}, 32'd1);
        reset = 1'b1;
        #1;
        check("t7_rst_mwr", {31'd0, m_write_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("t7_mrd", {31'd0, m_read_out}, 32'd0);
        check("t7_maddr", m_address_out, 32'd0);
        check("t7_mmask", {28'd0, m_write_mask_out}, 32'd0);
        check("t7_mdata", m_write_value_out, 32'd0);
        check("t7_irq", {31'd0, irq_out}, 32'd0);
        r0 = req_cycles;
        bus_read(RegSrc, v);   check("t7_src", v, 32'd0);
        bus_read(RegDst, v);   check("t7_dst", v, 32'd0);
        bus_read(RegCount, v); check("t7_count", v, 32'd0);
        bus_read(RegCtrl, v);  check("t7_ctrl", v, 32'd0);
        check("t7_no_reqs", 32'(req_cycles - r0), 32'd0);
        check("t7_no_write", 32'(wr_beats - w0), 32'd0);
        wait_n = 0;

        check("rd_wr_exclusive", 32'(both_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
